mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, max consecutive fetch losses before fetch gets forced priority (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles waiting for mem_ack before abort (2..255).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction fetch request, held until if_ack.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_rdata  output  32  fetched instruction, valid while if_ack.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 if_err  output  1  with if_ack, fetch aborted by timeout.
REQ-010 d_req  input  1  data request, held until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_be  input  4  byte enables.
REQ-015 d_rdata  output  32  load data, valid while d_ack.
REQ-016 d_ack  output  1  one-cycle data completion pulse.
REQ-017 d_err  output  1  with d_ack, data access aborted by timeout.
REQ-018 mem_req  output  1  request to unified memory, held until mem_ack or abort.
REQ-019 mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  output  registered copies of the granted request.
REQ-020 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-021 mem_ack  input  1  memory completion, one cycle.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE.
REQ-023 IDLE: no request -> stay; only if_req -> BUSY_I; only d_req -> BUSY_D; both -> BUSY_D unless starve_cnt == STARVE_MAX, then BUSY_I.
REQ-024 On grant, SHALL register address/we/wdata/be into mem_* and assert mem_req from the next cycle; fetch grant drives mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-025 starve_cnt (4 bit): +1 when both requests pending in IDLE and data granted; cleared when fetch granted; saturates at STARVE_MAX.
REQ-026 BUSY_x: mem_req=1; on mem_ack capture mem_rdata, go DONE; wait counter +1 per cycle; counter == TIMEOUT-1 without mem_ack -> go DONE with err flag set, mem_req dropped.
REQ-027 mem_ack and timeout in same cycle: mem_ack wins, err=0.
REQ-028 DONE: exactly one cycle; assert ack (and err if set) of the granted requester only; rdata = captured value (0 on error or store); mem_req=0; next state IDLE.
REQ-029 Latency: request sampled in IDLE at cycle N, mem_req from N+1, mem_ack at cycle M -> requester ack at M+1, IDLE at M+2 (minimum 3 cycles with mem_ack at N+1).
REQ-030 Requests arriving while not IDLE SHALL be held pending and arbitrated at next IDLE; a requester drops req in DONE cycle, so no re-grant of a completed request.
REQ-031 mem_ack outside BUSY_x SHALL be ignored.
REQ-032 if_rdata/d_rdata SHALL hold last value between acks.

Reset
REQ-033 On rst: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_ack=d_ack=if_err=d_err=0, if_rdata=d_rdata=0, starve_cnt=0, wait counter=0.
REQ-034 rst during BUSY_x or DONE SHALL abort without any ack pulse; first grant possible in the cycle after rst deasserts.

Verification
REQ-035 if_req only, if_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0x00000013 -> mem_addr=0x100, mem_we=0, if_ack pulse with if_rdata=0x00000013, d_ack=0.
REQ-036 d_req store d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF, single d_ack, if_ack never.
REQ-037 if_req and d_req both held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 d_req load, mem_ack never returned, TIMEOUT=64 -> mem_req drops after 64 cycles, d_ack=1 with d_err=1, d_rdata=0.
REQ-039 rst asserted for one cycle in BUSY_I -> mem_req=0 next cycle, no if_ack, starve_cnt=0; pending if_req re-granted after rst.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
        output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
        input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port. Data wins ties unless fetch has
// lost STARVE_MAX times in a row; a memory access that never acks is aborted after TIMEOUT.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_t;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
    localparam logic [7:0] WaitLast  = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [3:0] starve_q;
    logic [7:0] wait_q;
    logic       grant_i;
    logic       grant_d;

    always_comb begin
        grant_d = bus.d_req && !(bus.if_req && (starve_q == StarveMax));
        grant_i = bus.if_req && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            starve_q      <= '0;
            wait_q        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.if_err <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.d_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    wait_q <= '0;
                    if (grant_d) begin
                        state_q       <= StBusyD;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.mem_be    <= bus.d_be;
                        // Only a contested data win counts against fetch.
                        if (bus.if_req && (starve_q < StarveMax)) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (grant_i) begin
                        state_q       <= StBusyI;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= 4'hF;
                        starve_q      <= '0;
                    end
                end
                StBusyI, StBusyD: begin
                    // mem_ack takes priority over a coincident timeout.
                    if (bus.mem_ack || (wait_q == WaitLast)) begin
                        state_q     <= StDone;
                        bus.mem_req <= 1'b0;
                        if (state_q == StBusyI) begin
                            bus.if_ack   <= 1'b1;
                            bus.if_err   <= !bus.mem_ack;
                            bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : 32'h0;
                        end else begin
                            bus.d_ack   <= 1'b1;
                            bus.d_err   <= !bus.mem_ack;
                            bus.d_rdata <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : 32'h0;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic, all
// compared against a transaction-level model that predicts grant order and completion times.
module tb_mem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Requester side: a pending request stays until the model says it completed.
    bit          i_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;

    // Outstanding transaction: granted at t_grant, last busy cycle t_end, ack at t_end+1.
    bit          t_act = 1'b0, t_src = 1'b0, t_err = 1'b0;
    int          t_grant = 0, t_end = 0;
    logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    logic        t_we = 1'b0;
    logic [3:0]  t_be = '0;

    int          starve = 0;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
    int          lat_mode = -1;
    int          p_if = 0, p_d = 0;
    bit          fix_rd_en = 1'b0;
    logic [31:0] fix_rd = '0;
    bit          grants[$];
    int          n_if_ack = 0, n_d_ack = 0, n_if_err = 0, n_d_err = 0, n_mreq = 0;
    int          a_i, a_d, a_ie, a_de, a_m;
    logic [9:0]  ord;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs, drive inputs for the coming edge, advance the model.
    task automatic step(input bit r);
        bit          busy;
        bit          ack_now;
        int          lat;
        logic [31:0] rd;
        busy    = t_act && (cyc > t_grant) && (cyc <= t_end);
        ack_now = t_act && (cyc == t_end + 1);
        if (ack_now) begin
            if (t_src) exp_d_rdata = t_err ? 32'h0 : t_rdata;
            else       exp_if_rdata = t_err ? 32'h0 : t_rdata;
        end
        if (chk_en) begin
            chk("mem_req", bus.mem_req, busy);
            if (busy) begin
                chk("mem_addr", bus.mem_addr, t_addr);
                chk("mem_we", bus.mem_we, t_we);
                chk("mem_wdata", bus.mem_wdata, t_wdata);
                chk("mem_be", bus.mem_be, t_be);
            end
            chk("if_ack", bus.if_ack, ack_now && !t_src);
            chk("if_err", bus.if_err, ack_now && !t_src && t_err);
            chk("d_ack", bus.d_ack, ack_now && t_src);
            chk("d_err", bus.d_err, ack_now && t_src && t_err);
            chk("if_rdata", bus.if_rdata, exp_if_rdata);
            chk("d_rdata", bus.d_rdata, exp_d_rdata);
            if (bus.if_ack === 1'b1) n_if_ack++;
            if (bus.d_ack === 1'b1) n_d_ack++;
            if (bus.if_err === 1'b1) n_if_err++;
            if (bus.d_err === 1'b1) n_d_err++;
            if (bus.mem_req === 1'b1) n_mreq++;
        end
        if (ack_now) begin
            if (t_src) d_pend = 1'b0;
            else       i_pend = 1'b0;
        end
        if (t_act && (cyc >= t_end + 2)) t_act = 1'b0;

        // Memory: ack at the planned cycle; stray acks only while nothing is outstanding.
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (busy) begin
            if (!r && (cyc == t_end) && !t_err) begin
                rd            = fix_rd_en ? fix_rd : $urandom;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd;
                t_rdata       = (t_src && t_we) ? 32'h0 : rd;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            bus.mem_ack = 1'b1;
        end

        if (!i_pend && ($urandom_range(0, 99) < p_if)) begin
            i_pend = 1'b1;
            i_addr = $urandom;
        end
        if (!d_pend && ($urandom_range(0, 99) < p_d)) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
        end
        rst         = r;
        bus.if_req  = i_pend;
        bus.if_addr = i_addr;
        bus.d_req   = d_pend;
        bus.d_we    = d_we;
        bus.d_addr  = d_addr;
        bus.d_wdata = d_wdata;
        bus.d_be    = d_be;

        if (r) begin
            t_act        = 1'b0;
            starve       = 0;
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            chk_en       = 1'b1;
        end else if (!t_act && (i_pend || d_pend)) begin
            t_src = d_pend && !(i_pend && (starve == STARVE_MAX));
            if (t_src) begin
                if (i_pend) starve++;
                t_addr = d_addr; t_we = d_we; t_wdata = d_wdata; t_be = d_be;
            end else begin
                starve = 0;
                t_addr = i_addr; t_we = 1'b0; t_wdata = '0; t_be = 4'hF;
            end
            if (lat_mode >= 0) lat = lat_mode;
            else lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5);
            t_err   = (lat == 0);
            t_grant = cyc;
            t_end   = cyc + ((lat == 0) ? TIMEOUT : lat);
            t_act   = 1'b1;
            grants.push_back(t_src);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic mark();
        a_i = n_if_ack; a_d = n_d_ack; a_ie = n_if_err; a_de = n_d_err; a_m = n_mreq;
    endtask

    task automatic drain();
        p_if = 0;
        p_d  = 0;
        for (int k = 0; k < 400 && (i_pend || d_pend || t_act); k++) step(1'b0);
        chk("drain_idle", {31'd0, (i_pend || d_pend || t_act)}, 32'd0);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        step(1'b1);
        step(1'b1);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", bus.mem_be, 4'h0);
        chk("rst_mem_req", bus.mem_req, 1'b0);

        // Single fetch, memory acks on the first busy cycle.
        mark();
        lat_mode = 1; fix_rd_en = 1'b1; fix_rd = 32'h0000_0013;
        i_pend = 1'b1; i_addr = 32'h100;
        repeat (5) step(1'b0);
        chk("t035_if_rdata", bus.if_rdata, 32'h13);
        chk("t035_mem_addr", bus.mem_addr, 32'h100);
        chk("t035_mem_we", bus.mem_we, 1'b0);
        chk("t035_if_acks", n_if_ack - a_i, 1);
        chk("t035_d_acks", n_d_ack - a_d, 0);

        // Store.
        mark();
        lat_mode = 2;
        d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        repeat (6) step(1'b0);
        chk("t036_mem_we", bus.mem_we, 1'b1);
        chk("t036_mem_be", bus.mem_be, 4'b0011);
        chk("t036_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t036_d_rdata", bus.d_rdata, 32'h0);
        chk("t036_d_acks", n_d_ack - a_d, 1);
        chk("t036_if_acks", n_if_ack - a_i, 0);

        // Both requesters always busy: fetch wins once every STARVE_MAX+1 grants.
        step(1'b1);
        grants.delete();
        lat_mode = -1; fix_rd_en = 1'b0;
        p_if = 100; p_d = 100;
        for (int k = 0; k < 2000 && grants.size() < 10; k++) step(1'b0);
        ord = '0;
        for (int k = 0; k < 10 && k < grants.size(); k++) ord[k] = grants[k];
        chk("t037_count", grants.size() >= 10, 1'b1);
        chk("t037_order", ord, 10'b01_1110_1111);
        drain();

        // Load to get non-zero d_rdata, then a load that never acks.
        lat_mode = 3; fix_rd_en = 1'b1; fix_rd = 32'hCAFE_F00D;
        d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
        repeat (6) step(1'b0);
        chk("load_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        mark();
        lat_mode = 0;
        d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h3004;
        repeat (70) step(1'b0);
        chk("t038_mreq_cycles", n_mreq - a_m, TIMEOUT);
        chk("t038_d_err", n_d_err - a_de, 1);
        chk("t038_d_rdata", bus.d_rdata, 32'h0);

        // mem_ack in the last allowed cycle still counts as success.
        mark();
        lat_mode = TIMEOUT; fix_rd = 32'h0000_0077;
        i_pend = 1'b1; i_addr = 32'h200;
        repeat (70) step(1'b0);
        chk("edge_if_err", n_if_err - a_ie, 0);
        chk("edge_if_acks", n_if_ack - a_i, 1);
        chk("edge_if_rdata", bus.if_rdata, 32'h77);

        // Reset in the middle of a fetch; the fetch is re-granted afterwards.
        mark();
        lat_mode = 0;
        i_pend = 1'b1; i_addr = 32'h340;
        repeat (3) step(1'b0);
        lat_mode = 1;
        step(1'b1);
        chk("t039_mem_req", bus.mem_req, 1'b0);
        chk("t039_no_ack", n_if_ack - a_i, 0);
        repeat (6) step(1'b0);
        chk("t039_if_acks", n_if_ack - a_i, 1);
        chk("t039_mem_addr", bus.mem_addr, 32'h340);

        // Random traffic with occasional resets.
        lat_mode = -1; fix_rd_en = 1'b0;
        p_if = 35; p_d = 35;
        for (int k = 0; k < 1500; k++) step($urandom_range(0, 299) == 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
